// File: rtl/ext_domain_power_seq.sv
// Power-gating sequencer for one external power domain: orders isolation, reset
// and switch control on power-down/power-up and times out on a missing switch ack.

module ext_domain_power_seq_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic switch_no,
    input logic iso_no,
    input logic rst_no,
    input logic busy_o,
    input logic powered_o
);

    // An open switch is only ever seen by a domain that is isolated and held in reset
    a_switch_open_safe: assert property (@(posedge clk_i) disable iff (!rst_ni)
        switch_no |-> (!iso_no && !rst_no))
        else $error("switch open while domain not isolated and reset");

    a_busy_powered_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(busy_o && powered_o))
        else $error("busy and powered asserted together");

endmodule

module ext_domain_power_seq #(
    parameter int unsigned ISO_DELAY   = 2,
    parameter int unsigned RST_DELAY   = 4,
    parameter int unsigned ACK_TIMEOUT = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_down_req_i,
    input  logic pwr_up_req_i,
    input  logic err_clr_i,
    input  logic switch_ack_ni,
    output logic switch_no,
    output logic iso_no,
    output logic rst_no,
    output logic busy_o,
    output logic powered_o,
    output logic error_o
);

    typedef enum logic [3:0] {
        ST_ON     = 4'd0,
        ST_PD_ISO = 4'd1,
        ST_PD_RST = 4'd2,
        ST_PD_SW  = 4'd3,
        ST_OFF    = 4'd4,
        ST_PU_SW  = 4'd5,
        ST_PU_RST = 4'd6,
        ST_PU_ISO = 4'd7,
        ST_ERR    = 4'd8
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             switch_n_q, switch_n_d;
    logic             iso_n_q, iso_n_d;
    logic             rst_n_q, rst_n_d;
    logic             busy_q, busy_d;
    logic             powered_q, powered_d;
    logic             error_q, error_d;
    logic             down_req_s;
    logic             up_req_s;

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        switch_n_d = switch_n_q;
        iso_n_d    = iso_n_q;
        rst_n_d    = rst_n_q;
        error_d    = error_q;
        // Conflicting simultaneous requests are dropped entirely
        down_req_s = pwr_down_req_i & ~pwr_up_req_i;
        up_req_s   = pwr_up_req_i & ~pwr_down_req_i;

        case (state_q)
            ST_ON: begin
                if (down_req_s) begin
                    iso_n_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_PD_ISO;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_PD_ISO: begin
                if (cnt_q == ISO_LAST) begin
                    rst_n_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_PD_RST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PD_RST: begin
                switch_n_d = 1'b1;
                cnt_d      = CNT_ZERO;
                state_d    = ST_PD_SW;
            end
            ST_PD_SW: begin
                // A valid ack on the limit cycle still wins over the timeout
                if (switch_ack_ni) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_OFF;
                end else if (cnt_q == ACK_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_OFF: begin
                if (up_req_s) begin
                    switch_n_d = 1'b0;
                    cnt_d      = CNT_ZERO;
                    state_d    = ST_PU_SW;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_PU_SW: begin
                if (!switch_ack_ni) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_PU_RST;
                end else if (cnt_q == ACK_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PU_RST: begin
                if (cnt_q == RST_LAST) begin
                    rst_n_d = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_PU_ISO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PU_ISO: begin
                iso_n_d = 1'b1;
                state_d = ST_ON;
            end
            ST_ERR: begin
                iso_n_d = 1'b0;
                rst_n_d = 1'b0;
                // Recovery always retries towards OFF with the switch opened
                if (err_clr_i) begin
                    error_d    = 1'b0;
                    switch_n_d = 1'b1;
                    cnt_d      = CNT_ZERO;
                    state_d    = ST_PD_SW;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d    = ST_ON;
                cnt_d      = CNT_ZERO;
                switch_n_d = 1'b0;
                iso_n_d    = 1'b1;
                rst_n_d    = 1'b1;
                error_d    = 1'b0;
            end
        endcase

        busy_d    = (state_d != ST_ON) && (state_d != ST_OFF) && (state_d != ST_ERR);
        powered_d = (state_d == ST_ON);
    end

    // State, counter and output registers; reset lands in the fully powered state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_ON;
            cnt_q      <= CNT_ZERO;
            switch_n_q <= 1'b0;
            iso_n_q    <= 1'b1;
            rst_n_q    <= 1'b1;
            busy_q     <= 1'b0;
            powered_q  <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            switch_n_q <= switch_n_d;
            iso_n_q    <= iso_n_d;
            rst_n_q    <= rst_n_d;
            busy_q     <= busy_d;
            powered_q  <= powered_d;
            error_q    <= error_d;
        end
    end

    assign switch_no = switch_n_q;
    assign iso_no    = iso_n_q;
    assign rst_no    = rst_n_q;
    assign busy_o    = busy_q;
    assign powered_o = powered_q;
    assign error_o   = error_q;

    ext_domain_power_seq_chk u_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .switch_no (switch_n_q),
        .iso_no    (iso_n_q),
        .rst_no    (rst_n_q),
        .busy_o    (busy_q),
        .powered_o (powered_q)
    );

endmodule

// File: tb/tb_ext_domain_power_seq.sv
// Self-checking bench for ext_domain_power_seq: two instances (default timeout and
// ACK_TIMEOUT=8), each fed by a switch-cell model that delays switch_no into the ack.

module tb_ext_domain_power_seq;

    localparam int unsigned LOGN = 8192;
    // Output vectors ordered {switch_no, iso_no, rst_no, busy_o, powered_o, error_o}
    localparam logic [5:0] V_ON     = 6'b011010;
    localparam logic [5:0] V_PD_ISO = 6'b001100;
    localparam logic [5:0] V_PD_RST = 6'b000100;
    localparam logic [5:0] V_PD_SW  = 6'b100100;
    localparam logic [5:0] V_OFF    = 6'b100000;
    localparam logic [5:0] V_PU_SW  = 6'b000100;
    localparam logic [5:0] V_PU_RST = 6'b000100;
    localparam logic [5:0] V_PU_ISO = 6'b001100;
    localparam logic [5:0] V_ERR    = 6'b000001;

    typedef struct {
        int unsigned cyc;
        bit          which;
        logic [5:0]  val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic down_a = 1'b0, up_a = 1'b0, clr_a = 1'b0, ack_a;
    logic sw_a, iso_a, rstd_a, busy_a, pw_a, err_a;
    logic down_b = 1'b0, up_b = 1'b0, clr_b = 1'b0, ack_b;
    logic sw_b, iso_b, rstd_b, busy_b, pw_b, err_b;
    logic [5:0] outs_a, outs_b;

    logic [63:0] hist_a = '0;
    logic [63:0] hist_b = '0;
    logic [5:0]  lat_a = 6'd16;
    logic [5:0]  lat_b = 6'd7;
    logic        stuck_b = 1'b0;

    int unsigned cyc = 0;
    logic [5:0]  log_a [0:LOGN-1];
    logic [5:0]  log_b [0:LOGN-1];
    exp_t        sb [$];
    exp_t        e;
    logic [5:0]  got;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ext_domain_power_seq dut_a (
        .clk_i(clk), .rst_ni(rst_n), .pwr_down_req_i(down_a), .pwr_up_req_i(up_a),
        .err_clr_i(clr_a), .switch_ack_ni(ack_a), .switch_no(sw_a), .iso_no(iso_a),
        .rst_no(rstd_a), .busy_o(busy_a), .powered_o(pw_a), .error_o(err_a)
    );

    ext_domain_power_seq #(.ACK_TIMEOUT(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .pwr_down_req_i(down_b), .pwr_up_req_i(up_b),
        .err_clr_i(clr_b), .switch_ack_ni(ack_b), .switch_no(sw_b), .iso_no(iso_b),
        .rst_no(rstd_b), .busy_o(busy_b), .powered_o(pw_b), .error_o(err_b)
    );

    assign outs_a = {sw_a, iso_a, rstd_a, busy_a, pw_a, err_a};
    assign outs_b = {sw_b, iso_b, rstd_b, busy_b, pw_b, err_b};

    // Switch-cell model: ack is switch_no seen lat cycles later; B can be held open
    assign ack_a = hist_a[lat_a - 6'd1];
    assign ack_b = stuck_b ? 1'b1 : hist_b[lat_b - 6'd1];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        hist_a <= rst_n ? {hist_a[62:0], sw_a} : 64'd0;
        hist_b <= rst_n ? {hist_b[62:0], sw_b} : 64'd0;
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_a[cyc[12:0]] = outs_a;
            log_b[cyc[12:0]] = outs_b;
        end
    end

    task automatic push_exp(input int unsigned c, input bit w, input logic [5:0] v,
                            input string n);
        exp_t x;
        x.cyc = c; x.which = w; x.val = v; x.name = n;
        sb.push_back(x);
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        int unsigned r;
        repeat (3) @(negedge clk);
        push_exp(cyc, 1'b0, V_ON, "reset_a");
        push_exp(cyc, 1'b1, V_ON, "reset_b");
        rst_n = 1'b1;
        r = cyc;
        wait_to(r + 2);
        up_a = 1'b1;
        push_exp(r + 3, 1'b0, V_ON, "up_in_on_ignored");
        @(negedge clk);
        up_a = 1'b0;
        wait_to(r + 4);
        clr_a = 1'b1;
        push_exp(r + 5, 1'b0, V_ON, "clr_outside_err");
        @(negedge clk);
        clr_a = 1'b0;
        push_exp(r + 10, 1'b0, V_ON, "idle10_a");
        push_exp(r + 10, 1'b1, V_ON, "idle10_b");
        wait_to(r + 10);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_power_down();
        int unsigned k;
        down_a = 1'b1;
        k = cyc + 1;
        push_exp(k, 1'b0, V_PD_ISO, "pd_iso_k");
        push_exp(k + 1, 1'b0, V_PD_ISO, "pd_iso_k1");
        push_exp(k + 2, 1'b0, V_PD_RST, "pd_rst");
        push_exp(k + 3, 1'b0, V_PD_SW, "pd_sw");
        push_exp(k + 19, 1'b0, V_PD_SW, "pd_sw_wait_ack");
        push_exp(k + 20, 1'b0, V_OFF, "pd_off");
        @(negedge clk);
        down_a = 1'b0;
        wait_to(k + 25);
        down_a = 1'b1;
        push_exp(k + 26, 1'b0, V_OFF, "down_in_off_ignored");
        push_exp(k + 28, 1'b0, V_OFF, "down_in_off_stable");
        @(negedge clk);
        down_a = 1'b0;
        wait_to(k + 28);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_power_up();
        int unsigned k, j;
        up_a = 1'b1;
        k = cyc + 1;
        j = k + 32'(lat_a) + 1;
        push_exp(k, 1'b0, V_PU_SW, "pu_sw");
        push_exp(j - 1, 1'b0, V_PU_SW, "pu_sw_wait_ack");
        push_exp(j, 1'b0, V_PU_RST, "pu_rst");
        push_exp(j + 3, 1'b0, V_PU_RST, "pu_rst_hold");
        push_exp(j + 4, 1'b0, V_PU_ISO, "pu_rst_release");
        push_exp(j + 5, 1'b0, V_ON, "pu_on");
        @(negedge clk);
        up_a = 1'b0;
        wait_to(j + 1);
        down_a = 1'b1;
        push_exp(j + 2, 1'b0, V_PU_RST, "down_while_busy");
        @(negedge clk);
        down_a = 1'b0;
        wait_to(j + 5);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_ack_timeout();
        int unsigned k, k2, m;
        // Ack latency 7 lands exactly on the timeout limit cycle of the B instance
        down_b = 1'b1;
        k = cyc + 1;
        push_exp(k + 3, 1'b1, V_PD_SW, "to_pd_sw");
        push_exp(k + 10, 1'b1, V_PD_SW, "to_pd_sw_last");
        push_exp(k + 11, 1'b1, V_OFF, "ack_on_limit_wins");
        @(negedge clk);
        down_b = 1'b0;
        wait_to(k + 20);
        stuck_b = 1'b1;
        up_b = 1'b1;
        k2 = cyc + 1;
        push_exp(k2, 1'b1, V_PU_SW, "stuck_pu_sw");
        push_exp(k2 + 7, 1'b1, V_PU_SW, "stuck_before_limit");
        push_exp(k2 + 8, 1'b1, V_ERR, "stuck_err");
        @(negedge clk);
        up_b = 1'b0;
        wait_to(k2 + 9);
        down_b = 1'b1;
        up_b = 1'b1;
        push_exp(k2 + 10, 1'b1, V_ERR, "req_in_err_ignored");
        @(negedge clk);
        down_b = 1'b0;
        up_b = 1'b0;
        wait_to(k2 + 12);
        clr_b = 1'b1;
        stuck_b = 1'b0;
        lat_b = 6'd2;
        m = k2 + 13;
        push_exp(m, 1'b1, V_PD_SW, "err_clr_retry");
        push_exp(m + 2, 1'b1, V_PD_SW, "retry_wait_ack");
        push_exp(m + 3, 1'b1, V_OFF, "retry_off");
        @(negedge clk);
        clr_b = 1'b0;
        wait_to(m + 3);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_both_reqs();
        int unsigned k;
        down_a = 1'b1;
        up_a = 1'b1;
        k = cyc + 1;
        push_exp(k, 1'b0, V_ON, "both_reqs_ignored");
        @(negedge clk);
        up_a = 1'b0;
        push_exp(k + 1, 1'b0, V_PD_ISO, "single_down");
        @(negedge clk);
        up_a = 1'b1;
        push_exp(k + 2, 1'b0, V_PD_ISO, "reqs_in_pd_iso");
        push_exp(k + 3, 1'b0, V_PD_RST, "pd_rst_on_time");
        push_exp(k + 4, 1'b0, V_PD_SW, "pd_sw_on_time");
        push_exp(k + 20, 1'b0, V_PD_SW, "pd_sw_wait");
        push_exp(k + 21, 1'b0, V_OFF, "single_seq_off");
        @(negedge clk);
        down_a = 1'b0;
        up_a = 1'b0;
        wait_to(k + 21);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid_seq();
        int unsigned k, j;
        up_a = 1'b1;
        k = cyc + 1;
        j = k + 32'(lat_a) + 1;
        push_exp(j + 1, 1'b0, V_PU_RST, "pre_reset_pu_rst");
        @(negedge clk);
        up_a = 1'b0;
        wait_to(j + 1);
        rst_n = 1'b0;
        push_exp(j + 2, 1'b0, V_ON, "mid_reset_a");
        push_exp(j + 2, 1'b1, V_ON, "mid_reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(j + 3, 1'b0, V_ON, "after_reset");
        push_exp(j + 6, 1'b0, V_ON, "after_reset_stable");
        wait_to(j + 6);
        @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
            if (e.cyc >= cyc || got !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b", e.name, e.cyc, got, e.val);
            end
        end
    endtask

    task automatic test_random_loop();
        int unsigned k, k2, j, l;
        for (int it = 0; it < 20; it++) begin
            // Settle long enough that the ack history is uniform before changing latency
            repeat (32) @(negedge clk);
            lat_a = 6'($urandom_range(30, 1));
            l = 32'(lat_a);
            down_a = 1'b1;
            k = cyc + 1;
            push_exp(k + 3, 1'b0, V_PD_SW, "rnd_pd_sw");
            push_exp(k + 3 + l, 1'b0, V_PD_SW, "rnd_pd_wait");
            push_exp(k + 4 + l, 1'b0, V_OFF, "rnd_off");
            @(negedge clk);
            down_a = 1'b0;
            wait_to(k + 6 + l);
            up_a = 1'b1;
            k2 = cyc + 1;
            j = k2 + l + 1;
            push_exp(j - 1, 1'b0, V_PU_SW, "rnd_pu_wait");
            push_exp(j, 1'b0, V_PU_RST, "rnd_pu_rst");
            push_exp(j + 5, 1'b0, V_ON, "rnd_on");
            @(negedge clk);
            up_a = 1'b0;
            wait_to(j + 5);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                got = e.which ? log_b[e.cyc[12:0]] : log_a[e.cyc[12:0]];
                if (e.cyc >= cyc || got !== e.val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d lat %0d: got %b expected %b",
                             e.name, e.cyc, l, got, e.val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_ack_timeout();
        test_both_reqs();
        test_reset_mid_seq();
        test_random_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
